gshare_pht: RTL and testbench

Gshare pattern history table for the branch predictor. It sits directly downstream of the global history register and consumes that register's history bits. Each branch is mapped to a 2-bit saturating counter by hashing its PC with the history. The block predicts in fetch combinationally, trains from the resolved branch in execute, and supports a multi-cycle sweep that clears the whole table.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/gshare_pht.sv | 124 ++++++++++++
 tb/tb_gshare_pht.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg -- shared branch-predictor types and helpers.
//   ctr2_t       : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   CTR_RESET    : counter value after reset or a clear sweep (WNT)
//   pht_state_t  : pattern-history-table control states (IDLE/CLEAR)
//   sat_ctr_next : saturating increment/decrement of a ctr2_t; intended for
//                  reuse by bimodal and tournament tables as well
// ---------------------------------------------------------------------------
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr2_t;

   localparam ctr2_t CTR_RESET = WNT;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } pht_state_t;

   // Counts toward ST on taken, toward SNT on not-taken; never wraps.
   function automatic ctr2_t sat_ctr_next(input ctr2_t ctr, input logic taken);
      ctr2_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ST) nxt = ctr2_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) nxt = ctr2_t'(ctr - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/gshare_pht.sv
// ---------------------------------------------------------------------------
// gshare_pht -- gshare pattern history table.
//   A table of 2^INDEX_WIDTH two-bit saturating counters, indexed by
//   PC[INDEX_WIDTH+1:2] XOR global history. Prediction is combinational,
//   training lands one cycle later, and clear_i starts a sweep that resets
//   one entry per cycle.
//
// Ports
//   clk_i, rst_ni      clock; synchronous active-low reset
//   pred_pc_i          fetch PC
//   pred_ghr_i         global history from the GHR
//   pred_taken_o       prediction (counter MSB), forced 0 while sweeping
//   pred_idx_o         hashed index, carried down the pipe to the update
//   update_en_i        resolved conditional branch present
//   update_idx_i       index captured at prediction time
//   br_taken_i         actual branch outcome
//   clear_i            request a full-table clear sweep
//   busy_o             clear sweep in progress
// ---------------------------------------------------------------------------
module gshare_pht
   import bp_pkg::*;
#(
   parameter int PC_WIDTH      = 32,
   parameter int HISTORY_WIDTH = 4,
   parameter int INDEX_WIDTH   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [PC_WIDTH-1:0]      pred_pc_i,
   input  logic [HISTORY_WIDTH-1:0] pred_ghr_i,
   output logic                     pred_taken_o,
   output logic [INDEX_WIDTH-1:0]   pred_idx_o,
   input  logic                     update_en_i,
   input  logic [INDEX_WIDTH-1:0]   update_idx_i,
   input  logic                     br_taken_i,
   input  logic                     clear_i,
   output logic                     busy_o
);

   localparam int DEPTH = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};

   if (INDEX_WIDTH < HISTORY_WIDTH) begin : g_bad_width
      $error("gshare_pht: INDEX_WIDTH must be >= HISTORY_WIDTH");
   end

   ctr2_t                  table_q [DEPTH];
   pht_state_t             state_q, state_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

   // Single write port, shared by training and the clear sweep.
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_idx;
   ctr2_t                  wr_val;

   // ------------------------------------------------------------------
   // Lookup
   // ------------------------------------------------------------------
   logic [INDEX_WIDTH-1:0] ghr_ext;
   logic                   unused_pc_bits;

   assign ghr_ext        = INDEX_WIDTH'(pred_ghr_i);
   assign pred_idx_o     = pred_pc_i[INDEX_WIDTH+1:2] ^ ghr_ext;
   assign unused_pc_bits = ^{pred_pc_i[PC_WIDTH-1:INDEX_WIDTH+2], pred_pc_i[1:0]};

   // Entries are half-cleared mid-sweep, so the prediction is suppressed.
   assign pred_taken_o   = (state_q == IDLE) && table_q[pred_idx_o][1];
   assign busy_o         = (state_q == CLEAR);

   // ------------------------------------------------------------------
   // Control: next state and write-select
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_val  = CTR_RESET;

      unique case (state_q)
         IDLE: begin
            // Training uses the index captured at prediction time, so it
            // hits the same counter even after the GHR has moved on.
            if (update_en_i) begin
               wr_en  = 1'b1;
               wr_idx = update_idx_i;
               wr_val = sat_ctr_next(table_q[update_idx_i], br_taken_i);
            end
            // A same-cycle update has already been applied above.
            if (clear_i) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            // Updates and further clear requests are dropped here.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            wr_val = CTR_RESET;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and table
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_RESET;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (wr_en) table_q[wr_idx] <= wr_val;
      end
   end

endmodule

// File: tb/tb_gshare_pht.sv
module tb_gshare_pht;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic [3:0]  ghr;
   logic        pred_taken;
   logic [3:0]  pred_idx;
   logic        update_en;
   logic [3:0]  update_idx;
   logic        br_taken;
   logic        clear;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model: counter value per entry, and cycles left in a sweep.
   int mdl [DEPTH];
   int left;

   gshare_pht #(.PC_WIDTH(32), .HISTORY_WIDTH(4), .INDEX_WIDTH(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pred_pc_i   (pc),
      .pred_ghr_i  (ghr),
      .pred_taken_o(pred_taken),
      .pred_idx_o  (pred_idx),
      .update_en_i (update_en),
      .update_idx_i(update_idx),
      .br_taken_i  (br_taken),
      .clear_i     (clear),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mdl[i] <= 1;
         left <= 0;
      end else if (left > 0) begin
         mdl[DEPTH - left] <= 1;
         left <= left - 1;
      end else begin
         if (update_en) begin
            if (br_taken) mdl[update_idx] <= (mdl[update_idx] >= 3) ? 3 : mdl[update_idx] + 1;
            else          mdl[update_idx] <= (mdl[update_idx] <= 0) ? 0 : mdl[update_idx] - 1;
         end
         if (clear) left <= DEPTH;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         int ei;
         ei = (int'(pc[5:2]) ^ int'(ghr));
         chk("idx", int'(pred_idx), ei);
         chk("busy", int'(busy), (left > 0) ? 1 : 0);
         chk("taken", int'(pred_taken), (left == 0 && mdl[ei] >= 2) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input int idx);
      pc  = 32'(idx) << 2;
      ghr = 4'd0;
      #1;
   endtask

   task automatic upd(input int idx, input bit t);
      update_en  = 1'b1;
      update_idx = 4'(idx);
      br_taken   = t;
      tick();
      update_en  = 1'b0;
      #1;
   endtask

   // Counts busy cycles from the current cycle on, with a bound.
   task automatic count_busy(input string name, input bit poke);
      int n;
      n = 0;
      for (int k = 0; k < 40 && busy; k++) begin
         n++;
         look(2);
         chk({name, "_taken0"}, int'(pred_taken), 0);
         if (poke && k == 10) begin
            update_en  = 1'b1;
            update_idx = 4'd2;
            br_taken   = 1'b1;
         end
         tick();
         update_en = 1'b0;
      end
      chk({name, "_len"}, n, 16);
   endtask

   initial begin
      rst_n = 1'b0; pc = '0; ghr = '0; update_en = 1'b0; update_idx = '0;
      br_taken = 1'b0; clear = 1'b0;

      // 1. reset
      tick();
      chk_en = 1'b1;
      rst_n = 1'b1;
      chk("rst_busy", int'(busy), 0);
      for (int i = 0; i < DEPTH; i++) begin
         look(i);
         chk("rst_taken", int'(pred_taken), 0);
      end

      // 2. hash
      pc = 32'h0000_0010; ghr = 4'b0001; #1;
      chk("hash_a", int'(pred_idx), 5);
      pc = 32'h0000_003C; ghr = 4'b1111; #1;
      chk("hash_b", int'(pred_idx), 0);

      // 3. saturation at index 5
      look(5);
      chk("sat_init", int'(pred_taken), 0);
      upd(5, 1); look(5); chk("sat_t1", int'(pred_taken), 1);
      upd(5, 1); look(5); chk("sat_t2", int'(pred_taken), 1);
      upd(5, 1); look(5); chk("sat_t3", int'(pred_taken), 1);
      upd(5, 0); look(5); chk("sat_n1", int'(pred_taken), 1);
      upd(5, 0); look(5); chk("sat_n2", int'(pred_taken), 0);
      upd(5, 0); look(5); chk("sat_n3", int'(pred_taken), 0);
      upd(5, 0); look(5); chk("sat_n4", int'(pred_taken), 0);
      upd(5, 1); look(5); chk("sat_lo_t", int'(pred_taken), 0);
      upd(5, 1); look(5); chk("sat_lo_t2", int'(pred_taken), 1);

      // 4. same-cycle read and update
      look(3);
      update_en = 1'b1; update_idx = 4'd3; br_taken = 1'b1; #1;
      chk("rw_same", int'(pred_taken), 0);
      tick();
      update_en = 1'b0; #1;
      chk("rw_next", int'(pred_taken), 1);

      // 5. clear sweep
      upd(2, 1); upd(2, 1); upd(9, 1); upd(9, 1);
      look(9); chk("pre_clr9", int'(pred_taken), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0; #1;
      chk("clr_busy", int'(busy), 1);
      count_busy("clr", 1'b1);
      look(2); chk("post_clr2", int'(pred_taken), 0);
      look(9); chk("post_clr9", int'(pred_taken), 0);
      chk("post_clr_busy", int'(busy), 0);

      // 6. reset mid-sweep
      upd(7, 1);
      look(7); chk("pre_rst7", int'(pred_taken), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; #1;
      chk("midrst_busy", int'(busy), 0);
      look(7); chk("midrst_7", int'(pred_taken), 0);
      look(5); chk("midrst_5", int'(pred_taken), 0);
      clear = 1'b1;
      tick();
      clear = 1'b0; #1;
      count_busy("reclr", 1'b0);

      // Random traffic checked by the compare process.
      for (int c = 0; c < 600; c++) begin
         pc         = $urandom;
         ghr        = 4'($urandom);
         update_en  = ($urandom_range(0, 2) != 0);
         update_idx = 4'($urandom);
         br_taken   = ($urandom_range(0, 3) != 0);
         clear      = ($urandom_range(0, 59) == 0);
         tick();
      end
      update_en = 1'b0; clear = 1'b0;
      tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
